// File: rtl/fp_unit_arbiter_pkg.sv
// Shared definitions for the Fp unit arbiter: tag width helper, AXI-stream
// mod width helper and the round-robin grant function.
package fp_unit_arbiter_pkg;

  // Upper bound on requesters handled by rr_grant().
  localparam int MAX_IN = 32;

  function automatic int tag_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // mod field width: byte count of the dat bus, at least 1 bit.
  function automatic int mod_bits(input int bits);
    int b;
    b = $clog2((bits + 7) / 8);
    return (b > 0) ? b : 1;
  endfunction

  // One-hot grant to the first set req bit at or after ptr, wrapping at n.
  function automatic logic [MAX_IN-1:0] rr_grant(input int unsigned ptr,
                                                 input logic [MAX_IN-1:0] req,
                                                 input int unsigned n);
    logic [MAX_IN-1:0] g;
    int unsigned       idx;
    logic              found;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_IN; i++) begin
      if (i < n && !found) begin
        idx = (ptr + i) % n;
        if (req[idx[$clog2(MAX_IN)-1:0]]) begin
          g[idx[$clog2(MAX_IN)-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fp_unit_arbiter_tag_fifo.sv
// In-order tag FIFO recording which requester issued each op in flight.
// Ports: i_push/i_tag write, i_pop read; o_head is the oldest tag,
// o_empty/o_count report occupancy. Push and pop may coincide.
module fp_unit_arbiter_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_tag,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic [AW:0]  o_count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr, rd;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr      <= '0;
      rd      <= '0;
      o_count <= '0;
    end else begin
      if (i_push) wr <= wr + 1'b1;
      if (i_pop)  rd <= rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr] <= i_tag;
  end

  assign o_head  = mem[rd];
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one pipelined Fp arithmetic unit between NUM_IN requesters.
// Round-robin issue into a registered request stage; the requester index of
// every issued op goes into an in-order tag FIFO, and each returning result is
// registered into the response slot of the requester at the FIFO head.
// Ports (AXI-stream bundles flattened to val/rdy/dat/ctl/sop/eop/err/mod):
//   i_req_*  requests from each requester      o_res_*  requests to the unit
//   i_res_*  results from the unit             o_rsp_*  results per requester
//   o_outstanding  ops issued, not yet returned
//   o_err          sticky: result arrived with no op outstanding
module fp_unit_arbiter
  import fp_unit_arbiter_pkg::*;
#(
  parameter int NUM_IN   = 2,
  parameter int REQ_BITS = 762,
  parameter int RES_BITS = 381,
  parameter int CTL_BITS = 16,
  parameter int MAX_OUT  = 16,
  localparam int TAG_BITS = tag_bits(NUM_IN),
  localparam int OUT_W    = $clog2(MAX_OUT) + 1,
  localparam int REQ_MOD  = mod_bits(REQ_BITS),
  localparam int RES_MOD  = mod_bits(RES_BITS)
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_IN-1:0]                  i_req_val,
  output logic [NUM_IN-1:0]                  i_req_rdy,
  input  logic [NUM_IN-1:0][REQ_BITS-1:0]    i_req_dat,
  input  logic [NUM_IN-1:0][CTL_BITS-1:0]    i_req_ctl,
  input  logic [NUM_IN-1:0]                  i_req_err,
  input  logic [NUM_IN-1:0][REQ_MOD-1:0]     i_req_mod,
  output logic                               o_res_val,
  input  logic                               o_res_rdy,
  output logic [REQ_BITS-1:0]                o_res_dat,
  output logic [CTL_BITS-1:0]                o_res_ctl,
  output logic                               o_res_sop,
  output logic                               o_res_eop,
  output logic                               o_res_err,
  output logic [REQ_MOD-1:0]                 o_res_mod,
  input  logic                               i_res_val,
  output logic                               i_res_rdy,
  input  logic [RES_BITS-1:0]                i_res_dat,
  input  logic [CTL_BITS-1:0]                i_res_ctl,
  input  logic                               i_res_err,
  input  logic [RES_MOD-1:0]                 i_res_mod,
  output logic [NUM_IN-1:0]                  o_rsp_val,
  input  logic [NUM_IN-1:0]                  o_rsp_rdy,
  output logic [NUM_IN-1:0][RES_BITS-1:0]    o_rsp_dat,
  output logic [NUM_IN-1:0][CTL_BITS-1:0]    o_rsp_ctl,
  output logic [NUM_IN-1:0]                  o_rsp_sop,
  output logic [NUM_IN-1:0]                  o_rsp_eop,
  output logic [NUM_IN-1:0]                  o_rsp_err,
  output logic [NUM_IN-1:0][RES_MOD-1:0]     o_rsp_mod,
  output logic [OUT_W-1:0]                   o_outstanding,
  output logic                               o_err
);

  localparam logic [OUT_W-1:0] FULL = OUT_W'(MAX_OUT);

  logic [TAG_BITS-1:0] ptr, gidx, head;
  logic [MAX_IN-1:0]   req_ext, gnt_full;
  logic [NUM_IN-1:0]   gnt, load;
  logic                can_issue, issue, fifo_empty, res_acc, pop;

  // ---------------- issue path ----------------
  // Occupancy uses the registered count, so a pop cannot free a slot for a
  // grant in the same cycle.
  assign can_issue = (~o_res_val | o_res_rdy) & (o_outstanding < FULL);

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_IN-1:0] = i_req_val;
  end

  assign gnt_full  = rr_grant(32'(ptr), req_ext, NUM_IN);
  assign gnt       = gnt_full[NUM_IN-1:0] & {NUM_IN{can_issue}};
  assign i_req_rdy = gnt;
  assign issue     = |gnt;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (gnt[i]) gidx = TAG_BITS'(i);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_val <= 1'b0;
      o_res_dat <= '0;
      o_res_ctl <= '0;
      o_res_err <= 1'b0;
      o_res_mod <= '0;
      ptr       <= '0;
    end else if (issue) begin
      o_res_val <= 1'b1;
      o_res_dat <= i_req_dat[gidx];
      o_res_ctl <= i_req_ctl[gidx];
      o_res_err <= i_req_err[gidx];
      o_res_mod <= i_req_mod[gidx];
      ptr       <= (gidx == TAG_BITS'(NUM_IN - 1)) ? '0 : gidx + 1'b1;
    end else if (o_res_rdy) begin
      o_res_val <= 1'b0;
    end
  end

  assign o_res_sop = 1'b1;
  assign o_res_eop = 1'b1;

  // ---------------- tag FIFO ----------------
  fp_unit_arbiter_tag_fifo #(.DEPTH(MAX_OUT), .W(TAG_BITS)) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (issue),
    .i_tag   (gidx),
    .i_pop   (pop),
    .o_head  (head),
    .o_empty (fifo_empty),
    .o_count (o_outstanding)
  );

  // ---------------- return path ----------------
  // With the FIFO empty the beat is unexpected: accept it so the unit does
  // not stall, drop it and flag o_err. Hold rdy low during reset.
  assign i_res_rdy = i_rst_n & (fifo_empty | ~o_rsp_val[head] | o_rsp_rdy[head]);
  assign res_acc   = i_res_val & i_res_rdy;
  assign pop       = res_acc & ~fifo_empty;

  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_IN; k++)
      load[k] = pop & (head == TAG_BITS'(k));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_val <= '0;
      o_rsp_dat <= '0;
      o_rsp_ctl <= '0;
      o_rsp_err <= '0;
      o_rsp_mod <= '0;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (load[k]) begin
          o_rsp_val[k] <= 1'b1;
          o_rsp_dat[k] <= i_res_dat;
          o_rsp_ctl[k] <= i_res_ctl;
          o_rsp_err[k] <= i_res_err;
          o_rsp_mod[k] <= i_res_mod;
        end else if (o_rsp_rdy[k]) begin
          o_rsp_val[k] <= 1'b0;
        end
      end
    end
  end

  assign o_rsp_sop = '1;
  assign o_rsp_eop = '1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    o_err <= 1'b0;
    else if (res_acc && fifo_empty)  o_err <= 1'b1;
  end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
module tb_fp_unit_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        i_req_val = '0, i_req_rdy;
  logic [1:0][15:0]  i_req_dat = '0;
  logic [1:0][7:0]   i_req_ctl = '0;
  logic [1:0]        i_req_err = '0;
  logic [1:0][0:0]   i_req_mod = '0;
  logic              o_res_val, o_res_rdy = 1'b1;
  logic [15:0]       o_res_dat;
  logic [7:0]        o_res_ctl;
  logic              o_res_sop, o_res_eop, o_res_err;
  logic [0:0]        o_res_mod;
  logic              i_res_val = 1'b0, i_res_rdy;
  logic [7:0]        i_res_dat = '0, i_res_ctl = '0;
  logic              i_res_err = 1'b0;
  logic [0:0]        i_res_mod = '0;
  logic [1:0]        o_rsp_val, o_rsp_rdy = '1;
  logic [1:0][7:0]   o_rsp_dat, o_rsp_ctl;
  logic [1:0]        o_rsp_sop, o_rsp_eop, o_rsp_err;
  logic [1:0][0:0]   o_rsp_mod;
  logic [2:0]        o_outstanding;
  logic              o_err;

  int checks = 0;
  int failures = 0;

  fp_unit_arbiter #(.NUM_IN(2), .REQ_BITS(16), .RES_BITS(8), .CTL_BITS(8), .MAX_OUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_rdy(i_req_rdy), .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl),
    .i_req_err(i_req_err), .i_req_mod(i_req_mod),
    .o_res_val(o_res_val), .o_res_rdy(o_res_rdy), .o_res_dat(o_res_dat), .o_res_ctl(o_res_ctl),
    .o_res_sop(o_res_sop), .o_res_eop(o_res_eop), .o_res_err(o_res_err), .o_res_mod(o_res_mod),
    .i_res_val(i_res_val), .i_res_rdy(i_res_rdy), .i_res_dat(i_res_dat), .i_res_ctl(i_res_ctl),
    .i_res_err(i_res_err), .i_res_mod(i_res_mod),
    .o_rsp_val(o_rsp_val), .o_rsp_rdy(o_rsp_rdy), .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl),
    .o_rsp_sop(o_rsp_sop), .o_rsp_eop(o_rsp_eop), .o_rsp_err(o_rsp_err), .o_rsp_mod(o_rsp_mod),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  // Issue one beat from a single requester (unit rdy assumed high).
  task automatic issue_one(input logic idx, input logic [15:0] d);
    @(negedge clk);
    i_req_val = '0; i_req_val[idx] = 1'b1; i_req_dat[idx] = d;
    @(posedge clk); #1;
    i_req_val = '0;
  endtask

  // Return results until nothing is outstanding (bounded).
  task automatic drain;
    o_rsp_rdy = '1; i_res_dat = '0; i_res_ctl = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_outstanding == 3'd0) break;
      i_res_val = 1'b1;
    end
    i_res_val = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_res_val !== 1'b0) begin failures++; $display("FAIL rst_res_val got=%b exp=0", o_res_val); end
    checks++; if (o_rsp_val !== 2'b00) begin failures++; $display("FAIL rst_rsp_val got=%b exp=00", o_rsp_val); end
    checks++; if (o_outstanding !== 3'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", o_outstanding); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", o_err); end
    i_res_val = 1'b1; #1;
    checks++; if (i_res_rdy !== 1'b0) begin failures++; $display("FAIL rst_res_rdy got=%b exp=0", i_res_rdy); end
    i_res_val = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Both requesters held: grants 0,1,0,1 then full; results route back in order.
  task automatic test_alternate;
    logic [1:0][7:0]  ectl;
    logic [1:0][15:0] edat;
    logic [1:0]       erdy;
    ectl = {8'hB1, 8'hA0};
    edat = {16'h2001, 16'h1000};
    i_req_ctl = ectl; i_req_dat = edat; i_req_err = 2'b10; i_req_mod = {1'b1, 1'b0};
    o_res_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_req_val = 2'b11;
      if (i > 0) begin
        checks++; if (o_res_val !== 1'b1 || o_res_ctl !== ectl[(i-1)%2] || o_res_dat !== edat[(i-1)%2])
          begin failures++; $display("FAIL alt_beat%0d got val=%b ctl=%h dat=%h exp ctl=%h dat=%h", i, o_res_val, o_res_ctl, o_res_dat, ectl[(i-1)%2], edat[(i-1)%2]); end
        checks++; if (o_res_err !== ((i % 2) == 0) || o_res_sop !== 1'b1 || o_res_eop !== 1'b1)
          begin failures++; $display("FAIL alt_err_sop%0d got err=%b sop=%b eop=%b", i, o_res_err, o_res_sop, o_res_eop); end
      end
      erdy = (i == 4) ? 2'b00 : ((i % 2) ? 2'b10 : 2'b01);
      #1;
      checks++; if (i_req_rdy !== erdy) begin failures++; $display("FAIL alt_grant%0d got=%b exp=%b", i, i_req_rdy, erdy); end
    end
    checks++; if (o_outstanding !== 3'd4) begin failures++; $display("FAIL alt_full got=%0d exp=4", o_outstanding); end
    i_req_val = '0;
    // Return four results; tags are 0,1,0,1.
    o_rsp_rdy = '1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        erdy = ((i - 1) % 2) ? 2'b10 : 2'b01;
        checks++; if (o_rsp_val !== erdy || o_rsp_dat[(i-1)%2] !== 8'(8'h10 + i - 1))
          begin failures++; $display("FAIL alt_rsp%0d got val=%b dat=%h", i, o_rsp_val, o_rsp_dat[(i-1)%2]); end
      end
      i_res_val = (i < 4); i_res_dat = 8'(8'h10 + i);
      @(negedge clk);
    end
    i_res_val = 1'b0;
    checks++; if (o_outstanding !== 3'd0 || o_err !== 1'b0) begin failures++; $display("FAIL alt_end got out=%0d err=%b exp 0 0", o_outstanding, o_err); end
  endtask

  // Requester 0 only, unit echoes dat after a 3-cycle delay.
  task automatic test_echo;
    logic [7:0] q_dat[$];
    int         q_due[$];
    int         b = 1, got = 0;
    o_res_rdy = 1'b1; o_rsp_rdy = '1; i_req_ctl = '0; i_req_err = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++; if (o_rsp_val[1] !== 1'b0) begin failures++; $display("FAIL echo_rsp1 got=%b exp=0", o_rsp_val[1]); end
      if (o_rsp_val[0]) begin
        got++;
        checks++; if (o_rsp_dat[0] !== 8'(got)) begin failures++; $display("FAIL echo_dat got=%h exp=%h", o_rsp_dat[0], 8'(got)); end
      end
      if (o_res_val) begin q_dat.push_back(o_res_dat[7:0]); q_due.push_back(c + 3); end
      i_req_val = {1'b0, b <= 5};
      i_req_dat[0] = 16'(b);
      i_res_val = (q_due.size() > 0) && (q_due[0] <= c);
      i_res_dat = (q_dat.size() > 0) ? q_dat[0] : 8'h00;
      #1;
      if (i_req_val[0] && i_req_rdy[0]) b++;
      if (i_res_val && i_res_rdy) begin void'(q_dat.pop_front()); void'(q_due.pop_front()); end
    end
    i_req_val = '0; i_res_val = 1'b0;
    checks++; if (got !== 5) begin failures++; $display("FAIL echo_count got=%0d exp=5", got); end
  endtask

  // MAX_OUT=4 reached: no grant; one result pops, grant resumes next cycle.
  task automatic test_max_out;
    o_res_rdy = 1'b1; o_rsp_rdy = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); i_req_val = 2'b01; i_req_dat[0] = 16'(i); #1;
      checks++; if (i_req_rdy !== 2'b01) begin failures++; $display("FAIL max_fill%0d got=%b exp=01", i, i_req_rdy); end
    end
    @(negedge clk); #1;
    checks++; if (o_outstanding !== 3'd4 || i_req_rdy !== 2'b00) begin failures++; $display("FAIL max_full got out=%0d rdy=%b exp 4 00", o_outstanding, i_req_rdy); end
    @(negedge clk); i_res_val = 1'b1; #1;
    checks++; if (i_req_rdy !== 2'b00 || i_res_rdy !== 1'b1) begin failures++; $display("FAIL max_popcycle got rdy=%b res_rdy=%b exp 00 1", i_req_rdy, i_res_rdy); end
    @(negedge clk); i_res_val = 1'b0; #1;
    checks++; if (o_outstanding !== 3'd3 || i_req_rdy !== 2'b01) begin failures++; $display("FAIL max_resume got out=%0d rdy=%b exp 3 01", o_outstanding, i_req_rdy); end
    @(negedge clk); i_req_val = '0;
    checks++; if (o_outstanding !== 3'd4) begin failures++; $display("FAIL max_refill got=%0d exp=4", o_outstanding); end
    drain();
  endtask

  // Tags 0,1,1,0 with requester 1 stalled: head tag 1 blocks the unit.
  task automatic test_inorder;
    issue_one(1'b0, 16'h0A); issue_one(1'b1, 16'h0B); issue_one(1'b1, 16'h0C); issue_one(1'b0, 16'h0D);
    o_rsp_rdy = 2'b01;
    @(negedge clk); i_res_val = 1'b1; i_res_dat = 8'h40; i_res_ctl = 8'hBF; #1;
    checks++; if (i_res_rdy !== 1'b1) begin failures++; $display("FAIL ord_rdy0 got=%b exp=1", i_res_rdy); end
    @(negedge clk);
    checks++; if (o_rsp_val !== 2'b01 || o_rsp_dat[0] !== 8'h40 || o_rsp_ctl[0] !== 8'hBF) begin failures++; $display("FAIL ord_r0 got val=%b dat=%h ctl=%h", o_rsp_val, o_rsp_dat[0], o_rsp_ctl[0]); end
    i_res_dat = 8'h41; i_res_ctl = 8'h00;
    @(negedge clk);
    checks++; if (o_rsp_val !== 2'b10 || o_rsp_dat[1] !== 8'h41) begin failures++; $display("FAIL ord_r1 got val=%b dat=%h exp 10 41", o_rsp_val, o_rsp_dat[1]); end
    i_res_dat = 8'h42; #1;
    checks++; if (i_res_rdy !== 1'b0) begin failures++; $display("FAIL ord_stall got=%b exp=0", i_res_rdy); end
    @(negedge clk);
    checks++; if (o_rsp_val !== 2'b10 || o_rsp_dat[1] !== 8'h41 || o_outstanding !== 3'd2 || i_res_rdy !== 1'b0)
      begin failures++; $display("FAIL ord_hold got val=%b dat=%h out=%0d rdy=%b", o_rsp_val, o_rsp_dat[1], o_outstanding, i_res_rdy); end
    o_rsp_rdy = 2'b11; #1;
    checks++; if (i_res_rdy !== 1'b1) begin failures++; $display("FAIL ord_release got=%b exp=1", i_res_rdy); end
    @(negedge clk);
    checks++; if (o_rsp_val !== 2'b10 || o_rsp_dat[1] !== 8'h42) begin failures++; $display("FAIL ord_r2 got val=%b dat=%h exp 10 42", o_rsp_val, o_rsp_dat[1]); end
    i_res_dat = 8'h43;
    @(negedge clk); i_res_val = 1'b0;
    checks++; if (o_rsp_val !== 2'b01 || o_rsp_dat[0] !== 8'h43 || o_outstanding !== 3'd0)
      begin failures++; $display("FAIL ord_r3 got val=%b dat=%h out=%0d", o_rsp_val, o_rsp_dat[0], o_outstanding); end
    @(negedge clk);
  endtask

  // Result with nothing outstanding: consumed, sticky o_err.
  task automatic test_unexpected;
    @(negedge clk); i_res_val = 1'b1; i_res_dat = 8'hEE; #1;
    checks++; if (i_res_rdy !== 1'b1) begin failures++; $display("FAIL unexp_rdy got=%b exp=1", i_res_rdy); end
    @(posedge clk); #1; i_res_val = 1'b0;
    @(negedge clk);
    checks++; if (o_err !== 1'b1 || o_rsp_val !== 2'b00) begin failures++; $display("FAIL unexp_err got err=%b rsp=%b exp 1 00", o_err, o_rsp_val); end
    issue_one(1'b1, 16'h55);
    drain();
    checks++; if (o_err !== 1'b1 || o_outstanding !== 3'd0) begin failures++; $display("FAIL unexp_sticky got err=%b out=%0d exp 1 0", o_err, o_outstanding); end
  endtask

  // Async reset with 3 in flight and pointer at 1; restart at requester 0.
  task automatic test_reset_mid;
    issue_one(1'b0, 16'h1); issue_one(1'b0, 16'h2); issue_one(1'b0, 16'h3);
    @(negedge clk);
    checks++; if (o_outstanding !== 3'd3) begin failures++; $display("FAIL mid_pre got=%0d exp=3", o_outstanding); end
    i_req_val = 2'b11;
    #2 rst_n = 1'b0; #1;
    checks++; if (o_res_val !== 1'b0 || o_rsp_val !== 2'b00 || o_outstanding !== 3'd0 || o_err !== 1'b0)
      begin failures++; $display("FAIL mid_async got res=%b rsp=%b out=%0d err=%b", o_res_val, o_rsp_val, o_outstanding, o_err); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (i_req_rdy !== 2'b01) begin failures++; $display("FAIL mid_ptr got=%b exp=01", i_req_rdy); end
    i_req_val = '0;
  endtask

  // Push and result on the same cycle with an empty FIFO: no bypass.
  task automatic test_push_with_result;
    @(negedge clk); i_req_val = 2'b01; i_req_dat[0] = 16'h77; i_res_val = 1'b1; #1;
    checks++; if (i_res_rdy !== 1'b1) begin failures++; $display("FAIL pwr_rdy got=%b exp=1", i_res_rdy); end
    @(posedge clk); #1; i_req_val = '0; i_res_val = 1'b0;
    @(negedge clk);
    checks++; if (o_err !== 1'b1 || o_outstanding !== 3'd1 || o_rsp_val !== 2'b00 || o_res_val !== 1'b1)
      begin failures++; $display("FAIL pwr_state got err=%b out=%0d rsp=%b res=%b exp 1 1 00 1", o_err, o_outstanding, o_rsp_val, o_res_val); end
    drain();
    checks++; if (o_outstanding !== 3'd0) begin failures++; $display("FAIL pwr_drain got=%0d exp=0", o_outstanding); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_echo();
    test_max_out();
    test_inorder();
    test_unexpected();
    test_reset_mid();
    test_push_with_result();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

endmodule
